// File: rtl/alu_pkg.sv
// ALU control codes and execute-stage FSM encodings, shared with the ALU control decoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for the three ops that go through the iterative shifter.
  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative 1-bit-per-cycle shifter: working register, down-counter and done flag.
// Latency: one cycle per shift position after load; done_o is high whenever the count is zero.
// Backpressure: the parent simply stops stepping; the value holds once the count reaches zero.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic [SHW-1:0]   cnt_i,
  output logic [WIDTH-1:0] val_o,
  output logic             done_o
);

  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;

  // One-position shift of the working value for the latched op.
  always_comb begin
    work_d = work_q;
    case (op_q)
      ALU_SLL: work_d = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRL: work_d = {1'b0, work_q[WIDTH-1:1]};
      ALU_SRA: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: work_d = work_q;
    endcase
  end

  // Load on start, otherwise step while positions remain; flush aborts and clears the count.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= ALU_ADD;
    end else if (load_i) begin
      work_q <= val_i;
      cnt_q  <= cnt_i;
      op_q   <= op_i;
    end else if (step_i && (cnt_q != '0)) begin
      work_q <= work_d;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

  assign val_o  = work_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_execute_unit.sv
// Execute stage: single-cycle ALU ops plus iterative shifts, results and flags registered for EX/MEM.
// Latency: 1 cycle for non-shift ops and zero shifts; shamt+1 cycles for shifts.
// Backpressure: valid/ready; output registers hold while out_valid && !out_ready, in_ready drops.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [1:0]       be_in,
  input  logic [4:0]       rd_in,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             ltu,
  output logic [1:0]       be_out,
  output logic [4:0]       rd_out,
  output logic             busy
);

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, lt_q, ltu_q;
  logic [1:0]       be_q;
  logic [4:0]       rd_q;
  // Side-band of the op sitting in the shifter, kept apart so a held result stays intact.
  logic             pend_lt_q, pend_ltu_q;
  logic [1:0]       pend_be_q;
  logic [4:0]       pend_rd_q;

  logic             slot_free, accept, start_shift, lt_c, ltu_c, sh_done;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res, sh_val;

  assign slot_free   = !out_valid_q || out_ready;
  assign in_ready    = (state_q == ST_IDLE) && slot_free && !flush;
  assign accept      = in_valid && in_ready;
  assign shamt       = src_b[SHW-1:0];
  assign start_shift = accept && is_shift(alu_ctrl) && (shamt != '0);
  assign lt_c        = $signed(src_a) < $signed(src_b);
  assign ltu_c       = src_a < src_b;

  // Single-cycle ALU; shifts land here only with a zero amount, which passes src_a through.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a + ~src_b + {{(WIDTH-1){1'b0}}, 1'b1};
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_c};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltu_c};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = src_a;
      default:  alu_res = '0;
    endcase
  end

  alu_shift_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (start_shift),
    .step_i  (state_q == ST_SHIFT),
    .op_i    (alu_ctrl),
    .val_i   (src_a),
    .cnt_i   (shamt),
    .val_o   (sh_val),
    .done_o  (sh_done)
  );

  // FSM and output registers: drain on out_ready, load on completion, flush aborts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      be_q        <= '0;
      rd_q        <= '0;
      pend_lt_q   <= 1'b0;
      pend_ltu_q  <= 1'b0;
      pend_be_q   <= '0;
      pend_rd_q   <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_shift) begin
            state_q    <= ST_SHIFT;
            pend_lt_q  <= lt_c;
            pend_ltu_q <= ltu_c;
            pend_be_q  <= be_in;
            pend_rd_q  <= rd_in;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
            lt_q        <= lt_c;
            ltu_q       <= ltu_c;
            be_q        <= be_in;
            rd_q        <= rd_in;
          end
        end
        ST_SHIFT: begin
          if (sh_done && slot_free) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            result_q    <= sh_val;
            zero_q      <= (sh_val == '0);
            lt_q        <= pend_lt_q;
            ltu_q       <= pend_ltu_q;
            be_q        <= pend_be_q;
            rd_q        <= pend_rd_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign be_out    = be_q;
  assign rd_out    = rd_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_alu_execute_unit.sv
// Bench for alu_execute_unit: transaction-level model checked every cycle, plus directed literal checks.
// Latency: model predicts 1 cycle for simple ops, shamt+1 for shifts.
// Backpressure: out_ready is driven low in the hold scenario.
module tb_alu_execute_unit;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  be_in;
  logic [4:0]  rd_in;
  logic [31:0] src_a, src_b;
  logic        in_ready, out_valid, zero, lt, ltu, busy;
  logic [31:0] result;
  logic [1:0]  be_out;
  logic [4:0]  rd_out;

  int n_chk  = 0;
  int n_fail = 0;

  alu_execute_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .be_in(be_in), .rd_in(rd_in), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .lt(lt), .ltu(ltu), .be_out(be_out), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference result straight from the op definitions.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Model state: what the output side must show, and an op waiting out its shift time.
  logic        m_ov, m_zero, m_lt, m_ltu, m_busy;
  logic [31:0] m_res;
  logic [1:0]  m_be;
  logic [4:0]  m_rd;
  int          m_wait;
  logic [31:0] p_res;
  logic        p_lt, p_ltu;
  logic [1:0]  p_be;
  logic [4:0]  p_rd;
  logic        sf, ir, is_sh;
  logic [31:0] r;

  initial begin
    m_ov = 0; m_zero = 0; m_lt = 0; m_ltu = 0; m_busy = 0; m_res = 0; m_be = 0; m_rd = 0; m_wait = 0;
    p_res = 0; p_lt = 0; p_ltu = 0; p_be = 0; p_rd = 0;
    forever begin
      @(posedge clk);
      sf = !m_ov || out_ready;
      ir = !m_busy && sf && !flush;
      if (reset) begin
        m_ov = 0; m_zero = 0; m_lt = 0; m_ltu = 0; m_busy = 0; m_res = 0; m_be = 0; m_rd = 0; m_wait = 0;
      end else if (flush) begin
        m_ov = 0; m_busy = 0; m_wait = 0;
      end else begin
        if (m_ov && out_ready) m_ov = 0;
        if (m_busy) begin
          if (m_wait > 0) m_wait--;
          else if (sf) begin
            m_ov = 1; m_res = p_res; m_zero = (p_res == 0); m_lt = p_lt; m_ltu = p_ltu;
            m_be = p_be; m_rd = p_rd; m_busy = 0;
          end
        end else if (in_valid && ir) begin
          r = ref_res(alu_ctrl, src_a, src_b);
          is_sh = (alu_ctrl == 4'd7) || (alu_ctrl == 4'd8) || (alu_ctrl == 4'd9);
          if (is_sh && src_b[4:0] != 5'd0) begin
            m_busy = 1; m_wait = int'(src_b[4:0]); p_res = r;
            p_lt = $signed(src_a) < $signed(src_b); p_ltu = src_a < src_b; p_be = be_in; p_rd = rd_in;
          end else begin
            m_ov = 1; m_res = r; m_zero = (r == 0);
            m_lt = $signed(src_a) < $signed(src_b); m_ltu = src_a < src_b; m_be = be_in; m_rd = rd_in;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("busy", 32'(busy), 32'(m_busy));
      check("in_ready", 32'(in_ready), 32'(!m_busy && (!m_ov || out_ready) && !flush));
      if (m_ov) begin
        check("result", result, m_res);
        check("zero", 32'(zero), 32'(m_zero));
        check("lt", 32'(lt), 32'(m_lt));
        check("ltu", 32'(ltu), 32'(m_ltu));
        check("be_out", 32'(be_out), 32'(m_be));
        check("rd_out", 32'(rd_out), 32'(m_rd));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] be, input logic [4:0] rd);
    alu_ctrl = op; src_a = a; src_b = b; be_in = be; rd_in = rd; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    alu_ctrl = 0; be_in = 0; rd_in = 0; src_a = 0; src_b = 0;
    cyc(); cyc();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_be_rd", {25'd0, be_out, rd_out}, 32'd0);
    reset = 0;
    cyc();

    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 2'b00, 5'd1);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_zero", 32'(zero), 32'd0);
    check("add_ovf_lt", 32'(lt), 32'd0);
    check("add_ovf_valid", 32'(out_valid), 32'd1);

    issue(4'd1, 32'd5, 32'd5, 2'b11, 5'd7);
    check("sub_result", result, 32'd0);
    check("sub_zero", 32'(zero), 32'd1);
    check("sub_be_rd", {25'd0, be_out, rd_out}, {25'd0, 2'b11, 5'd7});

    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 2'b00, 5'd2);
    check("slt_result", result, 32'd1);
    check("slt_flags", {30'd0, lt, ltu}, 32'b10);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, 2'b00, 5'd3);
    check("sltu_result", result, 32'd0);

    // Back-to-back accepts while the output drains.
    alu_ctrl = 4'd0; src_a = 32'd1; src_b = 32'd1; in_valid = 1;
    cyc();
    check("b2b_add", result, 32'd2);
    alu_ctrl = 4'd2; src_a = 32'h0000_F0F0; src_b = 32'h0000_FF00;
    cyc();
    check("b2b_and", result, 32'h0000_F000);
    alu_ctrl = 4'd3;
    cyc();
    check("b2b_or", result, 32'h0000_FFF0);
    in_valid = 0;

    issue(4'b0100, 32'd3, 32'd5, 2'b01, 5'd4);
    check("undef_result", result, 32'd0);
    check("undef_flags", {29'd0, zero, lt, ltu}, 32'b111);

    issue(4'd7, 32'h0000_1234, 32'd32, 2'b00, 5'd5);
    check("sll0_valid", 32'(out_valid), 32'd1);
    check("sll0_result", result, 32'h0000_1234);

    issue(4'd9, 32'h8000_0000, 32'd4, 2'b00, 5'd6);
    check("sra_busy", 32'(busy), 32'd1);
    check("sra_in_ready", 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin cyc(); k++; end
    check("sra_latency", 32'(k), 32'd5);
    check("sra_result", result, 32'hF800_0000);

    issue(4'd7, 32'd1, 32'd31, 2'b10, 5'd8);
    out_ready = 0;
    k = 0;
    while (!out_valid && k < 40) begin cyc(); k++; end
    check("sll31_latency", 32'(k), 32'd32);
    check("sll31_result", result, 32'h8000_0000);
    alu_ctrl = 4'd0; src_a = 32'd10; src_b = 32'd20; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_result", result, 32'h8000_0000);
    end
    out_ready = 1;
    cyc();
    in_valid = 0;
    check("after_hold_add", result, 32'd30);

    issue(4'd8, 32'hF000_0000, 32'd10, 2'b00, 5'd9);
    cyc();
    flush = 1; alu_ctrl = 4'd0; src_a = 32'd9; src_b = 32'd9; in_valid = 1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    cyc();
    flush = 0; in_valid = 0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) cyc();
    check("flush_no_late_result", 32'(out_valid), 32'd0);
    issue(4'd0, 32'd2, 32'd3, 2'b00, 5'd10);
    check("post_flush_add", result, 32'd5);

    issue(4'd8, 32'hFFFF_0000, 32'd20, 2'b01, 5'd11);
    cyc(); cyc(); cyc();
    reset = 1;
    cyc();
    reset = 0;
    check("midrst_valid_busy", {30'd0, out_valid, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_be_rd", {25'd0, be_out, rd_out}, 32'd0);
    issue(4'd1, 32'd3, 32'd5, 2'b00, 5'd12);
    check("sub_neg", result, 32'hFFFF_FFFE);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
